// File: rtl/poly_voice_mixer.sv
// poly_voice_mixer: NCH-voice envelope-scaled mixer with one shared multiplier, master gain and W-bit saturation.
module poly_voice_mixer #(
   parameter int W   = 16,
   parameter int NCH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sample_tick,
   input  logic [NCH*W-1:0] ch_sample,
   input  logic [NCH*W-1:0] ch_env,
   input  logic [NCH-1:0]   ch_enable,
   input  logic [W-1:0]     master_gain,
   output logic [W-1:0]     mix_out,
   output logic             mix_valid,
   output logic             busy,
   output logic             clip,
   output logic             overrun
);
   localparam int AW = W + $clog2(NCH) + 1;
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [1:0] IDLE = 2'd0, MAC = 2'd1, GAIN = 2'd2;
   logic [1:0]              state;
   logic [IW-1:0]           idx;
   logic signed [AW-1:0]    acc;
   logic [NCH*W-1:0]        snap_sample, snap_env;
   logic [NCH-1:0]          snap_en;
   logic [W-1:0]            snap_gain;
   logic signed [W-1:0]     cur_s;
   logic [W-1:0]            cur_e;
   logic signed [2*W:0]     prod;
   logic signed [W-1:0]     term;
   logic signed [AW+W:0]    gprod;
   logic signed [AW:0]      g;
   logic                    ovf;
   logic [W-1:0]            sat;
   logic                    last;
   assign cur_s = snap_sample[int'(idx)*W +: W];
   assign cur_e = snap_env[int'(idx)*W +: W];
   assign prod  = cur_s * $signed({1'b0, cur_e});
   assign term  = snap_en[idx] ? prod[2*W-1:W] : '0;
   assign gprod = acc * $signed({1'b0, snap_gain});
   assign g     = gprod[AW+W:W];
   // in range iff every bit from the W-1 sign position upward agrees
   assign ovf   = !((&g[AW:W-1]) || !(|g[AW:W-1]));
   assign sat   = ovf ? (g[AW] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : g[W-1:0];
   assign last  = (idx == IW'(NCH-1));
   assign busy  = (state != IDLE);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         acc         <= '0;
         snap_sample <= '0;
         snap_env    <= '0;
         snap_en     <= '0;
         snap_gain   <= '0;
         mix_out     <= '0;
         mix_valid   <= 1'b0;
         clip        <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         mix_valid <= 1'b0;
         overrun   <= sample_tick && busy;
         case (state)
            IDLE: if (sample_tick) begin
               snap_sample <= ch_sample;
               snap_env    <= ch_env;
               snap_en     <= ch_enable;
               snap_gain   <= master_gain;
               acc         <= '0;
               idx         <= '0;
               state       <= MAC;
            end
            MAC: begin
               acc   <= acc + AW'(term);
               idx   <= last ? '0 : idx + 1'b1;
               state <= last ? GAIN : MAC;
            end
            GAIN: begin
               mix_out   <= sat;
               clip      <= ovf;
               mix_valid <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
